sort_readout: RTL

SORT_READOUT -- requirements
Module: sort_readout

---
 rtl/sort_pkg.sv | 13 +
 rtl/sort_readout_if.sv | 22 ++
 rtl/sort_readout_rise_det.sv | 18 +
 rtl/sort_readout.sv | 92 +++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared defaults and FSM state encoding for the sorted-RAM readout block.
package sort_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int DW_DEF    = 8;

    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t CAP  = 3'd2;
    localparam state_t OUT  = 3'd3;
    localparam state_t FIN  = 3'd4;
endpackage

// File: rtl/sort_readout_if.sv
// RAM read port plus valid/ready output stream; master = readout engine, slave = RAM/sink side.
interface sort_readout_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic [AW-1:0] ram_add;
    logic          ram_rd;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output ram_add, ram_rd, out_data, out_valid, out_last,
        input  ram_data, out_ready
    );
    modport slave (
        input  ram_add, ram_rd, out_data, out_valid, out_last,
        output ram_data, out_ready
    );
endinterface

// File: rtl/sort_readout_rise_det.sv
// Registered rising-edge detector: rise is combinational from input vs. last-cycle copy.
// Latency: rise visible in the cycle the input first reads high; no backpressure.
// Backpressure: none, the copy tracks the input every cycle.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= 1'b0;
        else      r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/sort_readout.sv
// Streams DEPTH words from a registered-read RAM after each done_in rise; optional order check (READOUT_ORDER_CHECK_EN).
// Latency: first out_valid 3 edges after the rise is sampled, at least 3 cycles per word.
// Backpressure: out_data/out_last held in OUT until out_ready; no further RAM reads while stalled.
module sort_readout
    import sort_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            done_in,
    sort_readout_if.master  bus,
    output logic            busy,
    output logic            complete,
    output logic            order_err
);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_index;
    logic [DW-1:0] r_out_data;
    logic          w_rise;

    rise_det u_rise_det (
        .clk    (clk),
        .rst    (rst),
        .i_d    (done_in),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_rise) begin
                    r_state <= RD;
                    r_index <= '0;
                end
                RD:   r_state <= CAP;
                CAP: begin
                    r_out_data <= bus.ram_data;
                    r_state    <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    if (r_index == LAST_IDX) begin
                        r_state <= FIN;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= RD;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ram_rd    = (r_state == RD);
    assign bus.ram_add   = r_index;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_last  = (r_state == OUT) && (r_index == LAST_IDX);
    assign busy          = (r_state != IDLE);
    assign complete      = (r_state == FIN);

`ifdef READOUT_ORDER_CHECK_EN
    logic [DW-1:0] r_prev;
    logic          r_order_err;

    // Sorted data must be non-increasing; flag clears only when a fresh run starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev      <= '0;
            r_order_err <= 1'b0;
        end else if (r_state == IDLE && w_rise) begin
            r_order_err <= 1'b0;
        end else if (r_state == CAP) begin
            r_prev <= bus.ram_data;
            if (r_index != '0 && bus.ram_data > r_prev) r_order_err <= 1'b1;
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif
endmodule
